// File: rtl/gray_scale_frame_sequencer.sv
// rtl/gray_scale_frame_sequencer.sv - AXI4-Lite master that runs the HLS gray-scale core one frame per ap_start
// Completion is detected by AP_CTRL.ap_done polling or by the core interrupt line (ISR cleared afterwards).
module gray_scale_frame_sequencer #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FRAME_W    = 16,
  parameter int POLL_GAP   = 8,
  parameter int TIMEOUT    = 1048576
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    cmd_start,
  input  logic [FRAME_W-1:0]      cmd_frames,
  input  logic                    cmd_use_irq,
  input  logic                    cmd_abort,
  output logic                    status_busy,
  output logic                    status_done,
  output logic                    status_error,
  output logic [FRAME_W-1:0]      frames_done,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  input  logic                    interrupt
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_CFG_GIE, S_CFG_IER, S_START, S_WAIT,
    S_POLL, S_CLRISR, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t               state, state_n;
  logic [FRAME_W-1:0]   frames_lat;
  logic                 use_irq;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [GAP_W-1:0]     gap_cnt;
  logic [FRAME_W-1:0]   frames_inc;
  logic                 accept;
  logic                 wr_launch;
  logic                 rd_launch;
  logic [ADDR_WIDTH-1:0] wr_addr_n;
  logic                 wr_fin;
  logic                 rd_fin;
  logic                 unused_rdata;

  assign wr_fin       = m_axi_bvalid && m_axi_bready;
  assign rd_fin       = m_axi_rvalid && m_axi_rready;
  assign status_busy  = (state != S_IDLE);
  assign frames_inc   = (frames_done == frames_lat) ? frames_done : frames_done + FRAME_W'(1);
  assign unused_rdata = ^{m_axi_rdata[DATA_WIDTH-1:2], m_axi_rdata[0]};

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    wr_launch = 1'b0;
    rd_launch = 1'b0;
    wr_addr_n = '0;
    case (state)
      S_IDLE: if (cmd_start) begin
        accept = 1'b1;
        if (cmd_frames == '0)  state_n = S_DONE;
        else if (cmd_use_irq)  state_n = S_CFG_GIE;
        else                   state_n = S_START;
      end
      S_CFG_GIE: if (wr_fin) state_n = (m_axi_bresp != 2'b00) ? S_ERR : S_CFG_IER;
      S_CFG_IER: if (wr_fin) state_n = (m_axi_bresp != 2'b00) ? S_ERR : S_START;
      S_START:   if (wr_fin) state_n = (m_axi_bresp != 2'b00) ? S_ERR : S_WAIT;
      // interrupt outranks abort, abort outranks timeout
      S_WAIT: begin
        if (use_irq && interrupt)                              state_n = S_CLRISR;
        else if (cmd_abort)                                    state_n = S_DONE;
        else if (tmo_cnt >= TMO_W'(TIMEOUT))                   state_n = S_ERR;
        else if (!use_irq && gap_cnt == GAP_W'(POLL_GAP - 1))  state_n = S_POLL;
      end
      S_POLL: if (rd_fin) begin
        if (m_axi_rresp != 2'b00) state_n = S_ERR;
        else if (m_axi_rdata[1])  state_n = S_NEXT;
        else                      state_n = S_WAIT;
      end
      S_CLRISR: if (wr_fin) state_n = (m_axi_bresp != 2'b00) ? S_ERR : S_NEXT;
      S_NEXT: begin
        if (frames_inc == frames_lat) state_n = S_DONE;
        else if (cmd_abort)           state_n = S_DONE;
        else                          state_n = S_START;
      end
      S_DONE:  state_n = S_IDLE;
      S_ERR:   state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase

    // every transaction state is entered from a different state, so entry marks issue
    if (state_n != state) begin
      case (state_n)
        S_CFG_GIE: begin wr_launch = 1'b1; wr_addr_n = ADDR_WIDTH'(8'h04); end
        S_CFG_IER: begin wr_launch = 1'b1; wr_addr_n = ADDR_WIDTH'(8'h08); end
        S_START:   begin wr_launch = 1'b1; wr_addr_n = ADDR_WIDTH'(8'h00); end
        S_CLRISR:  begin wr_launch = 1'b1; wr_addr_n = ADDR_WIDTH'(8'h0C); end
        S_POLL:    rd_launch = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state         <= S_IDLE;
      frames_lat    <= '0;
      use_irq       <= 1'b0;
      tmo_cnt       <= '0;
      gap_cnt       <= '0;
      frames_done   <= '0;
      status_done   <= 1'b0;
      status_error  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
    end else begin
      state       <= state_n;
      status_done <= (state == S_DONE);

      if (accept) begin
        frames_lat   <= cmd_frames;
        use_irq      <= cmd_use_irq;
        frames_done  <= '0;
        status_error <= 1'b0;
      end
      if (state == S_ERR)  status_error <= 1'b1;
      if (state == S_NEXT) frames_done  <= frames_inc;

      // timeout spans the whole frame wait, including the polling reads
      if (state == S_START)
        tmo_cnt <= '0;
      else if ((state == S_WAIT || state == S_POLL) && tmo_cnt < TMO_W'(TIMEOUT))
        tmo_cnt <= tmo_cnt + TMO_W'(1);

      if (state == S_WAIT && state_n == S_WAIT) gap_cnt <= gap_cnt + GAP_W'(1);
      else                                      gap_cnt <= '0;

      if (wr_launch) begin
        m_axi_awaddr  <= wr_addr_n;
        m_axi_wdata   <= DATA_WIDTH'(1);
        m_axi_wstrb   <= '1;
        m_axi_awvalid <= 1'b1;
        m_axi_wvalid  <= 1'b1;
        m_axi_bready  <= 1'b1;
      end else begin
        if (m_axi_awvalid && m_axi_awready) m_axi_awvalid <= 1'b0;
        if (m_axi_wvalid && m_axi_wready)   m_axi_wvalid  <= 1'b0;
        if (wr_fin)                         m_axi_bready  <= 1'b0;
      end

      if (rd_launch) begin
        m_axi_araddr  <= '0;
        m_axi_arvalid <= 1'b1;
        m_axi_rready  <= 1'b1;
      end else begin
        if (m_axi_arvalid && m_axi_arready) m_axi_arvalid <= 1'b0;
        if (rd_fin)                         m_axi_rready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gray_scale_frame_sequencer.sv
// tb/tb_gray_scale_frame_sequencer.sv - directed bench for gray_scale_frame_sequencer with a behavioural control-bus slave
module tb_gray_scale_frame_sequencer;

  logic        aclk = 1'b0;
  logic        areset;
  logic        cmd_start, cmd_use_irq, cmd_abort;
  logic [15:0] cmd_frames;
  logic        status_busy, status_done, status_error;
  logic [15:0] frames_done;
  logic [4:0]  m_axi_awaddr, m_axi_araddr;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready, interrupt;

  always #5 aclk = ~aclk;

  gray_scale_frame_sequencer #(
    .ADDR_WIDTH(5), .DATA_WIDTH(32), .FRAME_W(16), .POLL_GAP(8), .TIMEOUT(100)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_start(cmd_start), .cmd_frames(cmd_frames), .cmd_use_irq(cmd_use_irq), .cmd_abort(cmd_abort),
    .status_busy(status_busy), .status_done(status_done), .status_error(status_error),
    .frames_done(frames_done),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .interrupt(interrupt)
  );

  // slave configuration (written by the test) and bookkeeping (written by the slave)
  int         cfg_done_after = 0, cfg_irq_delay = 0, cfg_aw_delay = 0, cfg_ar_delay = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  int         n_wr = 0, n_start = 0, n_rd = 0, n_b = 0, n_bad = 0, rd_since = 0;
  int         aw_cnt = 0, ar_cnt = 0, irq_cnt = 0, aw_cyc = 0, w_cyc = 0;
  int         aw_cyc_last = 0, w_cyc_last = 0;
  logic       aw_stable = 1'b1, aw_stable_last = 1'b1;
  logic       aw_fire = 0, w_fire = 0, b_fire = 0, ar_fire = 0, r_fire = 0;
  logic       aw_got = 0, w_got = 0, rd_pend = 0;
  logic [4:0] aw_addr_l = 0, aw_addr_first = 0, ar_addr_l = 0;
  logic [31:0] w_data_l = 0;
  logic [3:0] w_strb_l = 0;
  logic [4:0] wlog [0:255];
  int         n_done = 0, n_valid = 0;

  // inputs for a cycle are decided at its falling edge; handshakes commit at the following falling edge
  always @(negedge aclk) begin
    if (areset) begin
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
      m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; interrupt = 0;
      aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
      aw_got = 0; w_got = 0; rd_pend = 0; aw_cnt = 0; ar_cnt = 0; irq_cnt = 0; aw_cyc = 0; w_cyc = 0;
    end else begin
      if (aw_fire) begin aw_got = 1; aw_cyc_last = aw_cyc; aw_stable_last = aw_stable; aw_cyc = 0; end
      if (w_fire)  begin w_got = 1; w_cyc_last = w_cyc; w_cyc = 0; end
      if (b_fire)  begin m_axi_bvalid = 0; n_b++; end
      if (ar_fire) rd_pend = 1;
      if (r_fire)  m_axi_rvalid = 0;
      if (aw_got && w_got && !m_axi_bvalid) begin
        m_axi_bvalid = 1; m_axi_bresp = cfg_bresp;
        wlog[n_wr[7:0]] = aw_addr_l; n_wr++;
        if (w_data_l != 32'd1 || w_strb_l != 4'hf) n_bad++;
        if (aw_addr_l == 5'h00) begin
          n_start++; rd_since = 0;
          if (cfg_irq_delay != 0) irq_cnt = cfg_irq_delay;
        end
        if (aw_addr_l == 5'h0c) interrupt = 0;
        aw_got = 0; w_got = 0;
      end
      if (rd_pend && !m_axi_rvalid) begin
        rd_since++; n_rd++;
        m_axi_rdata = (cfg_done_after != 0 && rd_since >= cfg_done_after) ? 32'h2 : 32'h4;
        m_axi_rresp = cfg_rresp; m_axi_rvalid = 1; rd_pend = 0;
        if (ar_addr_l != 5'h00) n_bad++;
      end
      if (irq_cnt != 0) begin irq_cnt--; if (irq_cnt == 0) interrupt = 1; end
      if (m_axi_awvalid) begin
        if (aw_cyc == 0) begin aw_addr_first = m_axi_awaddr; aw_stable = 1; end
        else if (m_axi_awaddr != aw_addr_first) aw_stable = 0;
        aw_cyc++;
        m_axi_awready = (aw_cnt >= cfg_aw_delay);
        if (m_axi_awready) begin aw_cnt = 0; aw_addr_l = m_axi_awaddr; end else aw_cnt++;
      end else m_axi_awready = 0;
      if (m_axi_wvalid) begin
        w_cyc++; m_axi_wready = 1; w_data_l = m_axi_wdata; w_strb_l = m_axi_wstrb;
      end else m_axi_wready = 0;
      if (m_axi_arvalid) begin
        m_axi_arready = (ar_cnt >= cfg_ar_delay);
        if (m_axi_arready) begin ar_cnt = 0; ar_addr_l = m_axi_araddr; end else ar_cnt++;
      end else m_axi_arready = 0;
      aw_fire = m_axi_awvalid && m_axi_awready;
      w_fire  = m_axi_wvalid && m_axi_wready;
      ar_fire = m_axi_arvalid && m_axi_arready;
      b_fire  = m_axi_bvalid && m_axi_bready;
      r_fire  = m_axi_rvalid && m_axi_rready;
    end
  end

  always @(negedge aclk) begin
    if (status_done) n_done++;
    if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) n_valid++;
  end

  int n_vec = 0, n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [15:0] fr, input logic irq);
    @(negedge aclk); cmd_frames = fr; cmd_use_irq = irq; cmd_start = 1'b1;
    @(negedge aclk); cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int k = 0; k < 3000 && n_done == d0; k++) @(negedge aclk);
    chk({tag, " done_pulses"}, 32'(n_done - d0), 32'd1);
    @(negedge aclk);
  endtask

  typedef struct {
    logic [15:0] frames;  logic irq;  int done_after;  int irq_delay;
    logic [1:0] bresp;  logic [1:0] rresp;
    int exp_fd;  int exp_err;  int exp_starts;  int exp_reads;  int exp_writes;  logic [31:0] exp_sig;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int s_wr, s_start, s_rd, s_bad, s_done, s_b, s_valid;
  logic [31:0] sig;

  initial begin
    // write-address signature packs the low address nibble of each write, oldest first
    vecs[0] = '{16'd3, 1'b0, 2, 0,  2'd0, 2'd0, 3, 0, 3, 6,  3, 32'h0};
    vecs[1] = '{16'd2, 1'b1, 0, 50, 2'd0, 2'd0, 2, 0, 2, 0,  6, 32'h480C0C};
    vecs[2] = '{16'd1, 1'b0, 1, 0,  2'd0, 2'd0, 1, 0, 1, 1,  1, 32'h0};
    vecs[3] = '{16'd2, 1'b0, 3, 0,  2'd0, 2'd0, 2, 0, 2, 6,  2, 32'h0};
    vecs[4] = '{16'd1, 1'b1, 0, 5,  2'd0, 2'd0, 1, 0, 1, 0,  4, 32'h480C};
    vecs[5] = '{16'd2, 1'b0, 1, 0,  2'd2, 2'd0, 0, 1, 1, 0,  1, 32'h0};
    vecs[6] = '{16'd2, 1'b0, 1, 0,  2'd0, 2'd2, 0, 1, 1, 1,  1, 32'h0};
    vecs[7] = '{16'd1, 1'b0, 0, 0,  2'd0, 2'd0, 0, 1, 1, -1, 1, 32'h0};
    vecs[8] = '{16'd1, 1'b0, 1, 0,  2'd0, 2'd0, 1, 0, 1, 1,  1, 32'h0};
    vecs[9] = '{16'd1, 1'b1, 0, 5,  2'd1, 2'd0, 0, 1, 0, 0,  1, 32'h4};

    areset = 1'b1; cmd_start = 1'b0; cmd_frames = '0; cmd_use_irq = 1'b0; cmd_abort = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready}, 32'd0);
    chk("rst addr", {22'd0, m_axi_awaddr, m_axi_araddr}, 32'd0);
    chk("rst wdata", m_axi_wdata, 32'd0);
    chk("rst status", {29'd0, status_busy, status_done, status_error}, 32'd0);
    chk("rst frames_done", {16'd0, frames_done}, 32'd0);
    areset = 1'b0;
    repeat (2) @(negedge aclk);

    for (int i = 0; i < NV; i++) begin
      cfg_done_after = vecs[i].done_after; cfg_irq_delay = vecs[i].irq_delay;
      cfg_bresp = vecs[i].bresp; cfg_rresp = vecs[i].rresp;
      s_wr = n_wr; s_start = n_start; s_rd = n_rd; s_bad = n_bad; s_done = n_done;
      run_cmd(vecs[i].frames, vecs[i].irq);
      chk($sformatf("v%0d busy_after_start", i), {31'd0, status_busy}, 32'd1);
      chk($sformatf("v%0d error_cleared", i), {31'd0, status_error}, 32'd0);
      wait_done(s_done, $sformatf("v%0d", i));
      chk($sformatf("v%0d frames_done", i), {16'd0, frames_done}, 32'(vecs[i].exp_fd));
      chk($sformatf("v%0d error", i), {31'd0, status_error}, 32'(vecs[i].exp_err));
      chk($sformatf("v%0d start_writes", i), 32'(n_start - s_start), 32'(vecs[i].exp_starts));
      if (vecs[i].exp_reads >= 0)
        chk($sformatf("v%0d reads", i), 32'(n_rd - s_rd), 32'(vecs[i].exp_reads));
      chk($sformatf("v%0d writes", i), 32'(n_wr - s_wr), 32'(vecs[i].exp_writes));
      sig = '0;
      for (int k = s_wr; k < n_wr; k++) sig = (sig << 4) | {28'd0, wlog[k[7:0]][3:0]};
      chk($sformatf("v%0d write_addr_seq", i), sig, vecs[i].exp_sig);
      chk($sformatf("v%0d bad_data", i), 32'(n_bad - s_bad), 32'd0);
      chk($sformatf("v%0d busy_after_done", i), {31'd0, status_busy}, 32'd0);
      repeat (3) @(negedge aclk);
    end
    cfg_bresp = 2'b00; cfg_rresp = 2'b00; cfg_irq_delay = 0;

    // zero frames: no bus traffic, done pulse two cycles after the start pulse
    s_valid = n_valid;
    @(negedge aclk); cmd_frames = 16'd0; cmd_use_irq = 1'b0; cmd_start = 1'b1;
    @(negedge aclk); cmd_start = 1'b0;
    chk("zero done_cycle1", {30'd0, status_done, status_busy}, 32'b01);
    @(negedge aclk);
    chk("zero done_cycle2", {30'd0, status_done, status_busy}, 32'b10);
    repeat (3) @(negedge aclk);
    chk("zero no_valid", 32'(n_valid - s_valid), 32'd0);

    // stalled awready, start ignored while busy
    cfg_done_after = 1; cfg_aw_delay = 5; s_b = n_b; s_done = n_done;
    @(negedge aclk); cmd_frames = 16'd1; cmd_use_irq = 1'b0; cmd_start = 1'b1;
    @(negedge aclk); cmd_start = 1'b0;
    chk("stall first_aw", {26'd0, m_axi_awvalid, m_axi_wvalid, m_axi_awaddr}, {26'd0, 2'b11, 5'h00});
    @(negedge aclk); cmd_frames = 16'd5; cmd_start = 1'b1;
    @(negedge aclk); cmd_start = 1'b0;
    for (int k = 0; k < 50 && n_b == s_b; k++) @(negedge aclk);
    repeat (2) @(negedge aclk);
    chk("stall aw_cycles", 32'(aw_cyc_last), 32'd6);
    chk("stall w_cycles", 32'(w_cyc_last), 32'd1);
    chk("stall aw_addr_stable", {31'd0, aw_stable_last}, 32'd1);
    cfg_aw_delay = 0;
    wait_done(s_done, "stall");
    chk("stall b_handshakes", 32'(n_b - s_b), 32'd1);
    chk("stall frames_done", {16'd0, frames_done}, 32'd1);
    repeat (3) @(negedge aclk);

    // abort while a slow read is outstanding
    cfg_done_after = 1; cfg_ar_delay = 4; s_rd = n_rd; s_done = n_done;
    run_cmd(16'd3, 1'b0);
    for (int k = 0; k < 500 && frames_done != 16'd1; k++) @(negedge aclk);
    for (int k = 0; k < 500 && !m_axi_arvalid; k++) @(negedge aclk);
    cmd_abort = 1'b1;
    wait_done(s_done, "abort");
    cmd_abort = 1'b0;
    chk("abort frames_done", {16'd0, frames_done}, 32'd2);
    chk("abort reads", 32'(n_rd - s_rd), 32'd2);
    chk("abort error", {31'd0, status_error}, 32'd0);
    cfg_ar_delay = 0;
    repeat (3) @(negedge aclk);

    // reset in the middle of a write
    cfg_aw_delay = 3;
    run_cmd(16'd1, 1'b0);
    chk("midrst awvalid_before", {31'd0, m_axi_awvalid}, 32'd1);
    areset = 1'b1;
    @(negedge aclk);
    chk("midrst valids", {27'd0, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, status_busy}, 32'd0);
    @(negedge aclk);
    areset = 1'b0; cfg_aw_delay = 0;
    repeat (2) @(negedge aclk);

    // recovery after reset
    cfg_done_after = 1; s_done = n_done;
    run_cmd(16'd1, 1'b0);
    wait_done(s_done, "recover");
    chk("recover frames_done", {16'd0, frames_done}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/gray_scale_frame_sequencer.md
# gray_scale_frame_sequencer

AXI4-Lite master that sequences the HLS gray-scale core through its `s_axi_CONTROL_BUS` slave, one frame per ap_start.
- On a command it optionally arms the core's interrupt registers, then for each of N frames writes ap_start and detects completion. Completion comes from polling AP_CTRL.ap_done or from the core's `interrupt` line, in which case the ISR is cleared afterwards.
- It sits between the processor-side video control logic and the gray-scale core, replacing software polling of the control bus.

## Interface
- `ADDR_WIDTH`, 5: control-bus address width.
- `DATA_WIDTH`, 32: control-bus data width.
- `FRAME_W`, 16: width of frame count and progress counter.
- `POLL_GAP`, 8: idle cycles between consecutive AP_CTRL polls (≥1).
- `TIMEOUT`, 1048576: max cycles spent waiting for one frame's completion.

Ports:
- `aclk`, in, 1: single clock.
- `areset`, in, 1: reset, synchronous, active-high.
- `cmd_start`, in, 1: 1-cycle pulse. Accepted only while `status_busy`=0.
- `cmd_frames`, in, FRAME_W: frames to run, sampled with `cmd_start`.
- `cmd_use_irq`, in, 1: 1 = completion by `interrupt`, 0 = polling. Sampled with `cmd_start`.
- `cmd_abort`, in, 1: level; stop after the current AXI transaction.
- `status_busy`, out, 1: command in progress.
- `status_done`, out, 1: 1-cycle pulse at the end of a command (normal or abort).
- `status_error`, out, 1: sticky; cleared by the next accepted `cmd_start`.
- `frames_done`, out, FRAME_W: frames completed in the current/last command.
- `m_axi_awaddr` out ADDR_WIDTH, `m_axi_awvalid` out 1, `m_axi_awready` in 1: write address channel.
- `m_axi_wdata` out DATA_WIDTH, `m_axi_wstrb` out DATA_WIDTH/8, `m_axi_wvalid` out 1, `m_axi_wready` in 1: write data channel.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1: write response channel.
- `m_axi_araddr` out ADDR_WIDTH, `m_axi_arvalid` out 1, `m_axi_arready` in 1: read address channel.
- `m_axi_rdata` in DATA_WIDTH, `m_axi_rresp` in 2, `m_axi_rvalid` in 1, `m_axi_rready` out 1: read data channel.
- `interrupt`, in, 1: core interrupt, level-high.

## Operation
- Core register map:
  - 0x00 AP_CTRL: bit0 ap_start, bit1 ap_done (clear-on-read), bit2 ap_idle.
  - 0x04 GIE.
  - 0x08 IER: bit0 done.
  - 0x0C ISR: bit0 done, toggle-on-write-1.
- All writes use `wstrb`=all ones.

States:
- IDLE: waits for `cmd_start`.
  - On accept: latch `cmd_frames` and `cmd_use_irq`; clear `frames_done` and `status_error`.
  - If frames=0: go to DONE with no AXI traffic.
  - Otherwise go to CFG if use_irq, else START.
- CFG: write 0x04←1, then 0x08←1, then go to START.
- START: write 0x00←0x1, then go to WAIT; the timeout counter is cleared on entry.
- WAIT:
  - Poll mode: count POLL_GAP cycles, then go to POLL.
  - IRQ mode: when `interrupt`=1, go to CLRISR.
  - Timeout counter reaching TIMEOUT goes to ERR.
  - `cmd_abort`=1 goes to DONE.
- POLL: read 0x00.
  - If rdata[1]=1, go to NEXT.
  - Else return to WAIT; the timeout counter keeps running.
- CLRISR: write 0x0C←1, then go to NEXT.
- NEXT: `frames_done`+1.
  - If equal to latched frames, go to DONE.
  - Else if `cmd_abort`, go to DONE.
  - Else go to START.
- DONE: pulse `status_done`, go to IDLE.
- ERR: set `status_error`, go to DONE.

AXI transaction rules:
- Write: assert awvalid and wvalid together in the first cycle. Each channel drops independently after its handshake. `bready`=1 from issue until the B handshake.
  - A nonzero `bresp` goes to ERR after the transaction completes.
- Read: arvalid is held until arready. `rready`=1 until the R handshake.
  - A nonzero `rresp` goes to ERR and ignores rdata.
- VALID is never deasserted before its handshake. Abort and timeout never cut a transaction.
- Address and data are stable while VALID is high.
- `frames_done` saturates at latched frames. Counter width rules: the timeout counter is ceil(log2(TIMEOUT+1)) bits.

## Timing
- Reset state: all VALID and READY outputs 0, addr/data 0, `status_busy`=0, `status_done`=0, `status_error`=0, `frames_done`=0, FSM=IDLE.
- Reset mid-transaction: all VALID outputs are 0 in the cycle after `areset` is sampled.
- `status_busy` is 1 from the cycle after the accepted `cmd_start` through the DONE cycle, and 0 in the cycle after DONE.
- `cmd_start` while busy is ignored.
- Back-to-back command: a start is accepted in the cycle after `status_done`.
- With an always-ready slave:
  - A write takes 2 cycles: the VALID cycle, then the B cycle.
  - A read takes 2 cycles.
  - The first awvalid appears 1 cycle after `cmd_start`.
- `interrupt` and `cmd_abort` are sampled only in WAIT and NEXT.
  - In WAIT, interrupt has priority over abort, and abort has priority over timeout.

## Test plan
- Poll mode, frames=3, slave returns ap_done on the 2nd read of each frame:
  - Exactly 3 writes of 0x00←1 and 6 reads.
  - `frames_done`=3, one `status_done` pulse, `status_error`=0.
- IRQ mode, frames=2, `interrupt` raised 50 cycles after each start:
  - Write sequence 0x04←1, 0x08←1, then per frame 0x00←1 and 0x0C←1 (6 writes total).
  - `frames_done`=2.
- frames=0:
  - No VALID ever asserted.
  - `status_done` pulses 2 cycles after `cmd_start`.
- Slave holds awready=0 for 5 cycles with wready=1:
  - wvalid drops after 1 cycle; awvalid is held 6 cycles with a stable address.
  - Exactly one B handshake.
- TIMEOUT=100, ap_done never set:
  - `status_error`=1, `frames_done`=0, `status_done` pulses.
  - Next `cmd_start` clears `status_error`.
- `cmd_abort` asserted while a read is outstanding (arready delayed 4 cycles):
  - The read completes, then DONE with partial `frames_done`.
  - `areset` mid-write drops all VALID the next cycle.
